// File: rtl/f1_start_ctrl_if.sv
// ---------------------------------------------------------------------------
// f1_start_ctrl_if
// Groups the race-start controller's handshake and status signals so the
// controller and its environment connect through one bundle.
//
// Signals
//   trigger        start request, only a rising edge starts a run
//   react          driver reaction button, level-sampled
//   light_en       one-cycle advance pulse to the light-sequence FSM
//   lights_clr     one-cycle pulse clearing the light-sequence FSM to all-off
//   cmd_seq        high while the lights are building
//   cmd_delay      high during the random hold before lights out
//   step           light_en pulses issued in the current run, 0..8
//   reaction_time  last measured reaction, in clocks
//   reaction_valid one-cycle pulse when reaction_time updates
//   jump_start     sticky flag: react seen before lights out
//
// Modports
//   master  the environment driving trigger/react (testbench or host logic)
//   slave   the controller itself
// ---------------------------------------------------------------------------
interface f1_start_ctrl_if;

    logic        trigger;
    logic        react;
    logic        light_en;
    logic        lights_clr;
    logic        cmd_seq;
    logic        cmd_delay;
    logic [3:0]  step;
    logic [15:0] reaction_time;
    logic        reaction_valid;
    logic        jump_start;

    modport master (
        output trigger,
        output react,
        input  light_en,
        input  lights_clr,
        input  cmd_seq,
        input  cmd_delay,
        input  step,
        input  reaction_time,
        input  reaction_valid,
        input  jump_start
    );

    modport slave (
        input  trigger,
        input  react,
        output light_en,
        output lights_clr,
        output cmd_seq,
        output cmd_delay,
        output step,
        output reaction_time,
        output reaction_valid,
        output jump_start
    );

endinterface

// File: rtl/f1_start_ctrl.sv
// ---------------------------------------------------------------------------
// f1_start_ctrl
// Start-light controller for a race start. A rising edge on trigger builds
// eight lights, one every TICK_DIV clocks, then holds for a pseudo-random
// number of ticks taken from a free-running 7-bit LFSR, then fires the
// lights-out pulse. With the reaction timer built, the controller then
// measures the clocks until the driver presses react, and flags a jump start
// if react is pressed while the lights are still building or holding.
//
// Parameters
//   TICK_DIV   clocks per light step, legal range 2..65535
//
// Optional feature (macro REACTION_TIMER_EN)
//   defined  : REACT state, reaction counter, reaction outputs and jump-start
//              detection are built
//   undefined: react is ignored, reaction_time/reaction_valid/jump_start/
//              lights_clr are tied to 0, lights out returns straight to IDLE
//
// Ports
//   clk      single clock, all state changes on the rising edge
//   rst      synchronous active-high reset
//   ctrl_io  f1_start_ctrl_if slave modport (trigger/react in, status out)
// ---------------------------------------------------------------------------
module f1_start_ctrl #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic            clk,
    input  logic            rst,
    f1_start_ctrl_if.slave  ctrl_io
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEQ,
        DELAY,
        REACT
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] tickCnt_q, tickCnt_d;
    logic [3:0]  step_q, step_d;
    logic [6:0]  delayCnt_q, delayCnt_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic        trig_q;

    logic        rise;
    logic        tick;
    logic        lightEn;

`ifdef REACTION_TIMER_EN
    logic [15:0] rcnt_q, rcnt_d;
    logic [15:0] reactionTime_q, reactionTime_d;
    logic        reactionValid_q, reactionValid_d;
    logic        jumpStart_q, jumpStart_d;
    logic        lightsClr;
`endif

    // Only a fresh rising edge of trigger may start a run; a trigger that
    // is simply held high never restarts the sequence.
    assign rise = ctrl_io.trigger & ~trig_q;

    // Tick fires on the last clock of every TICK_DIV-long step.
    assign tick = (tickCnt_q == TICK_LAST);

    // The LFSR free-runs every clock, so the hold length depends on when
    // the run happened to reach lights-on, not on anything the driver sees.
    always_comb begin
        lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[2]};
    end

    // Next-state and pulse logic. React has priority over tick in SEQ and
    // DELAY so a jump start never coincides with a light advance, which
    // keeps light_en and lights_clr mutually exclusive.
    always_comb begin
        state_d    = state_q;
        tickCnt_d  = tickCnt_q;
        step_d     = step_q;
        delayCnt_d = delayCnt_q;
        lightEn    = 1'b0;
`ifdef REACTION_TIMER_EN
        rcnt_d          = rcnt_q;
        reactionTime_d  = reactionTime_q;
        reactionValid_d = 1'b0;
        jumpStart_d     = jumpStart_q;
        lightsClr       = 1'b0;
`endif

        if ((state_q == SEQ) || (state_q == DELAY)) begin
            tickCnt_d = tick ? 16'd0 : tickCnt_q + 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = SEQ;
                    tickCnt_d = 16'd0;
                    step_d    = 4'd0;
`ifdef REACTION_TIMER_EN
                    jumpStart_d = 1'b0;
`endif
                end
            end

            SEQ: begin
`ifdef REACTION_TIMER_EN
                if (ctrl_io.react) begin
                    lightsClr   = 1'b1;
                    jumpStart_d = 1'b1;
                    state_d     = IDLE;
                    step_d      = 4'd0;
                end else
`endif
                if (tick) begin
                    lightEn = 1'b1;
                    step_d  = step_q + 4'd1;
                    // The eighth light completes the build-up.
                    if (step_q == 4'd7) begin
                        state_d    = DELAY;
                        tickCnt_d  = 16'd0;
                        delayCnt_d = lfsr_q;
                    end
                end
            end

            DELAY: begin
`ifdef REACTION_TIMER_EN
                if (ctrl_io.react) begin
                    lightsClr   = 1'b1;
                    jumpStart_d = 1'b1;
                    state_d     = IDLE;
                    step_d      = 4'd0;
                end else
`endif
                if (tick) begin
                    if (delayCnt_q == 7'd1) begin
                        // Lights out.
                        lightEn = 1'b1;
`ifdef REACTION_TIMER_EN
                        state_d = REACT;
                        rcnt_d  = 16'd0;
`else
                        state_d = IDLE;
                        step_d  = 4'd0;
`endif
                    end else begin
                        delayCnt_d = delayCnt_q - 7'd1;
                    end
                end
            end

            REACT: begin
`ifdef REACTION_TIMER_EN
                rcnt_d = (rcnt_q == 16'hFFFF) ? rcnt_q : rcnt_q + 16'd1;
                if (ctrl_io.react) begin
                    reactionTime_d  = rcnt_q;
                    reactionValid_d = 1'b1;
                    state_d         = IDLE;
                    step_d          = 4'd0;
                end
`else
                state_d = IDLE;
                step_d  = 4'd0;
`endif
            end

            default: begin
                state_d = IDLE;
                step_d  = 4'd0;
            end
        endcase
    end

    // State register. Reset mid-run simply abandons the run; the light FSM
    // shares this reset, so no clearing pulse is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tickCnt_q  <= 16'd0;
            step_q     <= 4'd0;
            delayCnt_q <= 7'd0;
            lfsr_q     <= 7'h01;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tickCnt_q  <= tickCnt_d;
            step_q     <= step_d;
            delayCnt_q <= delayCnt_d;
            lfsr_q     <= lfsr_d;
            trig_q     <= ctrl_io.trigger;
        end
    end

`ifdef REACTION_TIMER_EN
    // Reaction timer registers. reaction_valid is registered so that it is
    // high in the same cycle the new reaction_time becomes visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_q          <= 16'd0;
            reactionTime_q  <= 16'd0;
            reactionValid_q <= 1'b0;
            jumpStart_q     <= 1'b0;
        end else begin
            rcnt_q          <= rcnt_d;
            reactionTime_q  <= reactionTime_d;
            reactionValid_q <= reactionValid_d;
            jumpStart_q     <= jumpStart_d;
        end
    end
`endif

    // Pulses and mode strobes are masked while rst is high so nothing
    // downstream moves during reset, even before the first reset edge.
    assign ctrl_io.light_en  = lightEn & ~rst;
    assign ctrl_io.cmd_seq   = (state_q == SEQ) & ~rst;
    assign ctrl_io.cmd_delay = (state_q == DELAY) & ~rst;
    assign ctrl_io.step      = step_q;

`ifdef REACTION_TIMER_EN
    assign ctrl_io.lights_clr     = lightsClr & ~rst;
    assign ctrl_io.reaction_time  = reactionTime_q;
    assign ctrl_io.reaction_valid = reactionValid_q & ~rst;
    assign ctrl_io.jump_start     = jumpStart_q;
`else
    assign ctrl_io.lights_clr     = 1'b0;
    assign ctrl_io.reaction_time  = 16'd0;
    assign ctrl_io.reaction_valid = 1'b0;
    assign ctrl_io.jump_start     = 1'b0;
`endif

endmodule

// File: tb/tb_f1_start_ctrl.sv
// ---------------------------------------------------------------------------
// tb_f1_start_ctrl
// Self-checking bench for f1_start_ctrl with TICK_DIV = 4. Each run is
// described by a few knobs (react cycle, jump-start point, trigger glitching,
// reset point) and the expected outputs of every cycle are worked out from
// the run's timeline: 32 build-up cycles with a light every 4th cycle, a
// hold of 4*L cycles where L is the LFSR value at the end of the build-up,
// then the reaction window when REACTION_TIMER_EN is defined.
// ---------------------------------------------------------------------------
module tb_f1_start_ctrl;

    localparam int unsigned TICK_DIV = 4;

    logic clk;
    logic rst;

    int          testCount;
    int          failCount;
    logic [6:0]  lfsrModel;
    logic [15:0] expRt;
    logic        expJump;

    f1_start_ctrl_if bus ();

    f1_start_ctrl #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_io (bus)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs the expected single-bit outputs and step into one word.
    function automatic logic [31:0] mk(input bit le, input bit lc, input bit cs,
                                       input bit cd, input bit rv, input bit js,
                                       input int stp);
        return {22'd0, le, lc, cs, cd, rv, js, 4'(stp)};
    endfunction

    // Same packing of what the DUT is currently showing.
    function automatic logic [31:0] obsVec();
        return {22'd0, bus.light_en, bus.lights_clr, bus.cmd_seq, bus.cmd_delay,
                bus.reaction_valid, bus.jump_start, bus.step};
    endfunction

    // The start-light LFSR step: shift left, feed back bit6 xor bit2.
    function automatic logic [6:0] lfsrNext(input logic [6:0] v);
        return {v[5:0], v[6] ^ v[2]};
    endfunction

    // Counts one comparison and reports it when it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one clock cycle of inputs, checks the outputs of that cycle and
    // advances the LFSR reference across the following rising edge.
    task automatic applyStimulus(input logic trg, input logic rct, input logic r,
                                 input logic [31:0] expected, input string tag);
        @(negedge clk);
        bus.trigger = trg;
        bus.react   = rct;
        rst         = r;
        #1;
        checkOutput(tag, obsVec(), expected);
        @(posedge clk);
        lfsrModel = rst ? 7'h01 : lfsrNext(lfsrModel);
    endtask

    // One complete start sequence.
    //   jumpAt  : run cycle (1..32 build-up, 33.. hold) with react high, 0 = none
    //   reactAt : REACT cycle in which the driver presses react
    //   glitch  : toggle trigger randomly during the run instead of holding it
    //   abortAt : hold cycle in which rst is asserted, 0 = none
    task automatic doRun(input int jumpAt, input int reactAt, input bit glitch,
                         input int abortAt);
        logic trg;
        bit   rct;
        int   L;

        // Idle gap; the first cycle keeps trigger where it was, so a trigger
        // still held from the last run must not start a new one.
        trg = bus.trigger;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(trg, 1'($urandom_range(0, 1)), 1'b0,
                          mk(0, 0, 0, 0, 0, expJump, 0), "idle");
            trg = 1'b0;
        end

        applyStimulus(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, expJump, 0), "rise");
        expJump = 1'b0;
        trg     = 1'b1;
        L       = 0;

        for (int s = 1; s <= 32; s++) begin
            if (glitch) trg = 1'($urandom_range(0, 1));
            rct = (s == jumpAt);
`ifdef REACTION_TIMER_EN
            if (rct) begin
                applyStimulus(trg, 1'b1, 1'b0, mk(0, 1, 1, 0, 0, 0, (s - 1) / 4), "jumpSeq");
                expJump = 1'b1;
                applyStimulus(trg, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 0), "afterJumpSeq");
                checkOutput("rtimeJumpSeq", 32'(bus.reaction_time), 32'(expRt));
                return;
            end
`endif
            if (s == 32) L = int'(lfsrModel);
            applyStimulus(trg, rct, 1'b0, mk(s % 4 == 0, 0, 1, 0, 0, 0, (s - 1) / 4), "seq");
        end

        for (int d = 1; d <= 4 * L; d++) begin
            if (glitch) trg = 1'($urandom_range(0, 1));
            rct = ((32 + d) == jumpAt);
            if (d == abortAt) begin
                applyStimulus(trg, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 8), "rstDuring");
                expRt = 16'd0;
                applyStimulus(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0), "rstAfter");
                checkOutput("rtimeRst", 32'(bus.reaction_time), 32'(expRt));
                return;
            end
`ifdef REACTION_TIMER_EN
            if (rct) begin
                applyStimulus(trg, 1'b1, 1'b0, mk(0, 1, 0, 1, 0, 0, 8), "jumpDelay");
                expJump = 1'b1;
                applyStimulus(trg, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 0), "afterJumpDelay");
                return;
            end
`endif
            applyStimulus(trg, rct, 1'b0, mk(d == 4 * L, 0, 0, 1, 0, 0, 8), "delay");
        end

`ifdef REACTION_TIMER_EN
        for (int j = 0; j <= reactAt; j++) begin
            applyStimulus(trg, 1'(j == reactAt), 1'b0, mk(0, 0, 0, 0, 0, 0, 8), "react");
        end
        expRt = 16'(reactAt);
        applyStimulus(trg, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 0, 0), "rvalid");
`endif
        checkOutput("rtime", 32'(bus.reaction_time), 32'(expRt));
    endtask

    initial begin
        testCount   = 0;
        failCount   = 0;
        rst         = 1'b1;
        bus.trigger = 1'b0;
        bus.react   = 1'b0;
        expRt       = 16'd0;
        expJump     = 1'b0;
        lfsrModel   = 7'h01;

        @(posedge clk);
        lfsrModel = 7'h01;
        applyStimulus(1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0), "reset");
        checkOutput("resetRtime", 32'(bus.reaction_time), 32'd0);

        // Plain run with trigger held high, react 10 cycles into REACT.
        doRun(0, 10, 1'b0, 0);
        // React pressed on build-up cycle 12, which is also a tick cycle.
        doRun(12, 5, 1'b1, 0);
        // React already high in the very first REACT cycle.
        doRun(0, 0, 1'b0, 0);
        // Reset asserted during the hold.
        doRun(0, 3, 1'b0, 2);
        // Randomised runs.
        for (int i = 0; i < 8; i++) begin
            doRun(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : 0,
                  int'($urandom_range(0, 20)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
        // A clean run after the random ones, ending in a settled idle.
        doRun(0, 7, 1'b1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, expJump, 0), "finalIdle");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/f1_start_ctrl.md
F1_START_CTRL -- requirements
Module: f1_start_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000, clocks per light step; legal range 2..65535.
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 trigger  input  1  start request; only a rising edge counts.
REQ-005 react  input  1  driver reaction button, level-sampled.
REQ-006 light_en  output  1  one-cycle advance pulse to the light-sequence FSM.
REQ-007 lights_clr  output  1  one-cycle pulse that clears the light-sequence FSM to all-off.
REQ-008 cmd_seq  output  1  high while lights are building.
REQ-009 cmd_delay  output  1  high during the random hold.
REQ-010 step  output  4  light_en pulses issued this run, 0..8.
REQ-011 reaction_time  output  16  last measured reaction, in clocks.
REQ-012 reaction_valid  output  1  one-cycle pulse when reaction_time updates.
REQ-013 jump_start  output  1  sticky flag: react was seen before lights out.

Function
REQ-014 FSM states: IDLE, SEQ, DELAY, REACT; cmd_seq = (state==SEQ), cmd_delay = (state==DELAY).
REQ-015 Edge detect: trig_q <= trigger each clock; rise = trigger & ~trig_q; rise is ignored outside IDLE.
REQ-016 IDLE, rise -> SEQ next cycle; same edge clears tick counter, step and jump_start.
REQ-017 Tick counter: cleared on entry to SEQ and DELAY, increments in SEQ/DELAY, tick = (cnt==TICK_DIV-1), wraps to 0 after tick.
REQ-018 SEQ: light_en = tick (combinational, same cycle); step increments on each pulse; the pulse that makes step 8 moves to DELAY.
REQ-019 LFSR: 7-bit, reset 7'h01, free-running every clock, next = {lfsr[5:0], lfsr[6]^lfsr[2]}.
REQ-020 On the SEQ->DELAY edge, delay_cnt loads the current lfsr value (1..127).
REQ-021 DELAY: on each tick, delay_cnt==1 -> light_en pulse (lights out) and exit; otherwise delay_cnt decrements; hold lasts delay_cnt*TICK_DIV clocks.
REQ-022 The DELAY exit goes to REACT if REACTION_TIMER_EN is defined, otherwise to IDLE.
REQ-023 REACT: rcnt clears on entry and increments each cycle, saturating at 16'hFFFF.
REQ-024 In REACT with react high: reaction_time <= rcnt (0 if react is high in the first REACT cycle), reaction_valid pulses for one cycle, next state IDLE.
REQ-025 Jump start (macro builds only): react high in SEQ or DELAY -> lights_clr one cycle, jump_start <= 1, next state IDLE.
REQ-026 In the jump-start cycle light_en is suppressed even if tick fires; react has priority.
REQ-027 step holds 8 during DELAY/REACT and clears to 0 on any return to IDLE.
REQ-028 light_en and lights_clr are never high together.

Reset
REQ-029 rst high at an edge: state IDLE, step 0, tick counter 0, delay_cnt 0, rcnt 0, reaction_time 0, jump_start 0, trig_q 0, lfsr 7'h01.
REQ-030 During and after reset, light_en, lights_clr, reaction_valid, cmd_seq and cmd_delay are 0.
REQ-031 Reset mid-run aborts without a lights_clr pulse; the light FSM shares rst.

Configuration
REQ-032 Macro REACTION_TIMER_EN defined: REACT state, rcnt, reaction output logic and jump-start detection are built.
REQ-033 Macro REACTION_TIMER_EN absent: react is ignored; reaction_time ties to 0; reaction_valid, jump_start and lights_clr tie to 0; DELAY returns to IDLE.

Verification (TICK_DIV=4)
REQ-034 Reset, trigger rises -> SEQ next cycle; light_en at SEQ cycles 4,8,...,32; step 1..8; cmd_seq high for 32 cycles.
REQ-035 Record lfsr at the SEQ->DELAY edge as L -> cmd_delay high exactly 4*L cycles; one light_en on the last cycle; step stays 8.
REQ-036 Macro on, react asserted 10 cycles after REACT entry -> reaction_time=10, reaction_valid one cycle, state IDLE, step 0.
REQ-037 Macro on, react pulsed at SEQ cycle 12 -> lights_clr one cycle, no light_en, jump_start=1 until next accepted trigger, step 0.
REQ-038 Trigger held high through a full run, plus extra edges in SEQ -> no restart; a new run needs a fresh rise in IDLE.
REQ-039 rst during DELAY -> all outputs at reset values next cycle; macro off -> a full run reaches IDLE after lights out, with reaction_valid never asserted.
